// File: rtl/rr_arb_mux.sv
// Round-robin N:1 arbiter/mux with a registered output stage; 1 cycle from input transfer to out_valid.
// Backpressure: while the output is held (out_valid && !out_ready) in_ready is zero; RR_ARB_MUX_LOCK_EN adds packet lock via in_last.
module rr_arb_mux #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [N-1:0]         in_last,
`endif
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_sel
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q, out_sel_d;

  logic [SW-1:0] arb_gnt;
  logic          arb_vld;
  logic [SW-1:0] gnt;
  logic          gnt_vld;
  logic [W-1:0]  gnt_dat;
  logic          load_en;
  logic          xfer;
  logic          adv;

  assign load_en = !out_valid_q || out_ready;

  // Descending scan so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    int j;
    logic [SW-1:0] idx;
    arb_gnt = '0;
    arb_vld = 1'b0;
    j       = 0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      idx = SW'(j);
      if (in_valid[idx]) begin
        arb_gnt = idx;
        arb_vld = 1'b1;
      end
    end
  end

`ifdef RR_ARB_MUX_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t        state_q, state_d;
  logic [SW-1:0] lock_g_q, lock_g_d;

  always_comb begin
    gnt     = arb_gnt;
    gnt_vld = arb_vld;
    if (state_q == LOCKED) begin
      gnt     = lock_g_q;
      gnt_vld = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    lock_g_d = lock_g_q;
    case (state_q)
      IDLE: begin
        if (xfer && !in_last[gnt]) begin
          state_d  = LOCKED;
          lock_g_d = gnt;
        end
      end
      LOCKED: begin
        if (xfer && in_last[gnt]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lock_g_q <= '0;
    end else begin
      state_q  <= state_d;
      lock_g_q <= lock_g_d;
    end
  end

  assign adv = xfer && in_last[gnt];
`else
  assign gnt     = arb_gnt;
  assign gnt_vld = arb_vld;
  assign adv     = xfer;
`endif

  always_comb begin
    gnt_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (SW'(i) == gnt) gnt_dat = in_data[i*W +: W];
    end
  end

  assign xfer = gnt_vld && load_en && in_valid[gnt];

  // Gated by rst_n so in_ready reads zero for the whole reset window.
  always_comb begin
    in_ready = '0;
    if (rst_n && gnt_vld && load_en) in_ready[gnt] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_en) out_valid_d = xfer;
    if (xfer) begin
      out_data_d = gnt_dat;
      out_sel_d  = gnt;
    end
    if (adv) ptr_d = (gnt == SW'(N - 1)) ? '0 : gnt + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux (N=4, W=8): vector table with hand-derived expectations plus a beat scoreboard.
module tb_rr_arb_mux;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;

  rr_arb_mux #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        rdy;
    logic [3:0]  ir;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  os;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] s;
  } exp_t;

  vec_t tbl [21];
  exp_t sbq [$];

  int errors = 0;
  int checks = 0;

  int m_ptr  = 0;
  bit m_ov   = 0;
  bit m_lock = 0;
  int m_lch  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_ov   = 0;
    m_lock = 0;
    m_lch  = 0;
    sbq.delete();
  endtask

  // Drives one cycle from a negedge, returns in_ready as sampled before the edge.
  task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic rdy,
                       input logic [3:0] lst, output logic [3:0] ir_s);
    int   g;
    bit   gv;
    bit   le;
    bit   x;
    logic [3:0] exp_ir;
    exp_t e;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    in_last   = lst;
    #1;
    ir_s = in_ready;
    le   = !m_ov || rdy;
    if (m_ov && rdy && sbq.size() > 0) void'(sbq.pop_front());
    gv = 0;
    g  = 0;
    if (m_lock) begin
      g  = m_lch;
      gv = 1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (!gv && v[j]) begin
          g  = j;
          gv = 1;
        end
      end
    end
    exp_ir = (gv && le) ? (4'b0001 << g) : 4'b0000;
    chk("in_ready_model", {28'd0, in_ready}, {28'd0, exp_ir});
    x = gv && le && v[g];
    if (x) begin
      e.d = d[g*8 +: 8];
      e.s = 2'(g);
      sbq.push_back(e);
`ifdef RR_ARB_MUX_LOCK_EN
      if (lst[g]) begin
        m_lock = 0;
        m_ptr  = (g + 1) % 4;
      end else begin
        m_lock = 1;
        m_lch  = g;
      end
`else
      m_ptr = (g + 1) % 4;
`endif
    end
    if (le) m_ov = x;
    @(posedge clk);
    #1;
    chk("out_valid_sb", {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov) begin
      if (sbq.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL scoreboard_empty actual=%0h required=beat", out_data);
      end else begin
        chk("out_data_sb", {24'd0, out_data}, {24'd0, sbq[0].d});
        chk("out_sel_sb", {30'd0, out_sel}, {30'd0, sbq[0].s});
      end
    end
    @(negedge clk);
  endtask

  logic [3:0] ir;
  logic [3:0] l_v   [6];
  logic [3:0] l_lst [6];
  logic [3:0] l_ir  [6];
  logic       l_ov  [6];
  logic [1:0] l_os  [6];

  initial begin
    // ch0=11 ch1=22 ch2=33 ch3=44 unless noted
    tbl[0]  = '{4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tbl[1]  = '{4'b1111, 32'h44332211, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[2]  = '{4'b1111, 32'h44332211, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[3]  = '{4'b1111, 32'h44332211, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl[4]  = '{4'b1111, 32'h44332211, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    tbl[5]  = '{4'b1111, 32'h44332211, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[6]  = '{4'b1111, 32'h44332211, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[7]  = '{4'b1111, 32'h44332211, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl[8]  = '{4'b1111, 32'h44332211, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
    tbl[9]  = '{4'b1111, 32'h44332211, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
    tbl[10] = '{4'b1111, 32'h44332211, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
    tbl[11] = '{4'b1111, 32'h44332211, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    tbl[12] = '{4'b1111, 32'h44332211, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[13] = '{4'b0000, 32'h44332211, 1'b1, 4'b0000, 1'b0, 8'h44, 2'd3};
    tbl[14] = '{4'b0000, 32'h44332211, 1'b0, 4'b0000, 1'b0, 8'h44, 2'd3};
    tbl[15] = '{4'b0011, 32'h0000BBAA, 1'b0, 4'b0001, 1'b1, 8'hAA, 2'd0};
    tbl[16] = '{4'b0011, 32'h0000BBAA, 1'b0, 4'b0000, 1'b1, 8'hAA, 2'd0};
    tbl[17] = '{4'b0010, 32'h0000BBAA, 1'b1, 4'b0010, 1'b1, 8'hBB, 2'd1};
    tbl[18] = '{4'b0001, 32'hDEADBE5A, 1'b1, 4'b0001, 1'b1, 8'h5A, 2'd0};
    tbl[19] = '{4'b1000, 32'h77FFFFFF, 1'b1, 4'b1000, 1'b1, 8'h77, 2'd3};
    tbl[20] = '{4'b0000, 32'hFFFFFFFF, 1'b1, 4'b0000, 1'b0, 8'h77, 2'd3};

    // Lock run from ptr=1: ch1 packet of 3 beats with a gap, then ch2, then ch0.
    l_v   = '{4'b0111, 4'b0101, 4'b0111, 4'b0111, 4'b0101, 4'b0001};
    l_lst = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0101, 4'b0001};
    l_ir  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0001};
    l_ov  = '{1'b1,    1'b0,    1'b1,    1'b1,    1'b1,    1'b1};
    l_os  = '{2'd1,    2'd1,    2'd1,    2'd1,    2'd2,    2'd0};

    rst_n     = 1'b0;
    in_valid  = 4'hF;
    in_data   = 32'h44332211;
    in_last   = 4'hF;
    out_ready = 1'b1;
    model_reset();
    #2;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", {24'd0, out_data}, 32'd0);
    chk("reset_out_sel", {30'd0, out_sel}, 32'd0);
    chk("reset_in_ready", {28'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("reset_held_out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].rdy, 4'hF, ir);
      chk($sformatf("tbl%0d_in_ready", i), {28'd0, ir}, {28'd0, tbl[i].ir});
      chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
      chk($sformatf("tbl%0d_out_data", i), {24'd0, out_data}, {24'd0, tbl[i].od});
      chk($sformatf("tbl%0d_out_sel", i), {30'd0, out_sel}, {30'd0, tbl[i].os});
    end

    // Async reset mid-stream with ptr parked at 2 and a beat held.
    cycle(4'hF, 32'h44332211, 1'b1, 4'hF, ir);
    cycle(4'hF, 32'h44332211, 1'b1, 4'hF, ir);
    chk("pre_rst_out_sel", {30'd0, out_sel}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", {24'd0, out_data}, 32'd0);
    chk("arst_in_ready", {28'd0, in_ready}, 32'd0);
    model_reset();
    in_valid = 4'h0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    cycle(4'hF, 32'h44332211, 1'b1, 4'hF, ir);
    chk("post_rst_in_ready", {28'd0, ir}, 32'h1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_first_sel", {30'd0, out_sel}, 32'd0);
    chk("post_rst_out_data", {24'd0, out_data}, 32'h11);

`ifdef RR_ARB_MUX_LOCK_EN
    for (int i = 0; i < 6; i++) begin
      cycle(l_v[i], 32'h44332211, 1'b1, l_lst[i], ir);
      chk($sformatf("lock%0d_in_ready", i), {28'd0, ir}, {28'd0, l_ir[i]});
      chk($sformatf("lock%0d_out_valid", i), {31'd0, out_valid}, {31'd0, l_ov[i]});
      chk($sformatf("lock%0d_out_sel", i), {30'd0, out_sel}, {30'd0, l_os[i]});
    end
`endif

    in_valid = 4'h0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
